uart_rx_checked: RTL and testbench

- UART receiver with error checking: 8 data bits LSB-first, 1 start bit, 1 stop bit, no parity.
- Pairs with the team's existing UART transmitter on the host link and feeds received bytes to the pattern-loading logic.
- Adds an input synchronizer, start-bit glitch rejection, framing-error and break detection, and a re-arm guard after line faults.

---
 rtl/uart_rx_checked_if.sv | 20 ++
 rtl/uart_rx_checked.sv | 153 +++++++++++++++
 tb/tb_uart_rx_checked.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_checked_if.sv
// Serial-line bundle for uart_rx_checked. The driver side (master) owns the
// line, and the receiver side (slave) owns the byte, status and pulse outputs.
interface uart_rx_checked_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Frame_Err;
  logic       o_Break;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Frame_Err, o_Break
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Frame_Err, o_Break
  );
endinterface

// File: rtl/uart_rx_checked.sv
// 8N1 UART receiver. It adds an input synchronizer, start-glitch rejection,
// framing-error and break reporting, and a re-arm guard that waits for the
// line to return high.
module uart_rx_checked #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input logic               i_Clock,
  input logic               i_Reset,
  uart_rx_checked_if.slave  bus
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        active_q, active_d;
  logic        ferr_q, ferr_d;
  logic        brk_q, brk_d;
  logic        sync1_q, sync2_q;
  logic        rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
      brk_q    <= brk_d;
      sync1_q  <= bus.i_Rx_Serial;
      sync2_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    active_d = active_q;
    ferr_d   = 1'b0;
    brk_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        // A start bit that is no longer low at its centre is treated as a glitch.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d  = DATA;
            idx_d    = '0;
            active_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            brk_d   = (shift_q == 8'h00);
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      CLEANUP: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end

      WAIT_IDLE: begin
        active_d = 1'b0;
        cnt_d    = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign bus.o_Rx_DV     = dv_q;
  assign bus.o_Rx_Byte   = byte_q;
  assign bus.o_Rx_Active = active_q;
  assign bus.o_Frame_Err = ferr_q;
  assign bus.o_Break     = brk_q;

endmodule

// File: tb/tb_uart_rx_checked.sv
// Directed and randomized frames for uart_rx_checked at CLKS_PER_BIT=8. Each
// outcome is predicted from the framing rules and compared with the pulses
// observed on the interface.
module tb_uart_rx_checked;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  uart_rx_checked_if bus();

  uart_rx_checked #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  int         checks = 0;
  int         failures = 0;
  int         dv_cnt = 0, fe_cnt = 0, brk_cnt = 0;
  int         overlap_cnt = 0, brk_alone_cnt = 0;
  int         dv_cyc = 0, prev_dv_cyc = 0;
  logic [7:0] dv_byte = 8'h00;
  bit         active_seen = 0;

  // Reference state: the last correctly framed byte.
  logic [7:0] exp_byte = 8'h00;
  int         start_cyc = 0;

  always @(negedge clk) begin
    if (bus.o_Rx_DV) begin
      dv_cnt      = dv_cnt + 1;
      dv_byte     = bus.o_Rx_Byte;
      prev_dv_cyc = dv_cyc;
      dv_cyc      = cyc;
    end
    if (bus.o_Frame_Err) fe_cnt = fe_cnt + 1;
    if (bus.o_Break) brk_cnt = brk_cnt + 1;
    if (bus.o_Rx_DV && bus.o_Frame_Err) overlap_cnt = overlap_cnt + 1;
    if (bus.o_Break && !bus.o_Frame_Err) brk_alone_cnt = brk_alone_cnt + 1;
    if (bus.o_Rx_Active) active_seen = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.i_Rx_Serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_bit(input logic v);
    bus.i_Rx_Serial = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Sends one frame and checks its outcome against the framing rules. A good
  // stop bit gives one DV with the byte. A low stop bit gives one framing error
  // (and a break if all bits were zero) and leaves the held byte unchanged.
  task automatic do_frame(input string tag, input logic [7:0] b, input logic stop_b);
    int dv0, fe0, brk0, lat;
    dv0 = dv_cnt; fe0 = fe_cnt; brk0 = brk_cnt;
    active_seen = 0;
    start_cyc = cyc;
    set_bit(1'b0);
    for (int i = 0; i < 8; i++) set_bit(b[i]);
    set_bit(stop_b);
    if (stop_b) exp_byte = b;
    chk({tag, "_dv"},  dv_cnt - dv0,  stop_b ? 1 : 0);
    chk({tag, "_fe"},  fe_cnt - fe0,  stop_b ? 0 : 1);
    chk({tag, "_brk"}, brk_cnt - brk0, (!stop_b && b == 8'h00) ? 1 : 0);
    chk({tag, "_byte"}, bus.o_Rx_Byte, exp_byte);
    chk({tag, "_active_seen"}, active_seen, 1);
    chk({tag, "_active_end"}, bus.o_Rx_Active, 0);
    if (stop_b) begin
      lat = dv_cyc - start_cyc;
      chk({tag, "_latency"}, (lat >= 76 && lat <= 80), 1);
    end else begin
      idle(CPB);
    end
  endtask

  initial begin
    int dv0, fe0, brk0;
    bus.i_Rx_Serial = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", bus.o_Rx_DV, 0);
    chk("rst_byte", bus.o_Rx_Byte, 8'h00);
    chk("rst_active", bus.o_Rx_Active, 0);
    chk("rst_fe", bus.o_Frame_Err, 0);
    chk("rst_brk", bus.o_Break, 0);
    rst = 1'b0;
    idle(10);

    do_frame("a5", 8'hA5, 1'b1);
    idle(5);

    // Back-to-back frames with no idle gap between them.
    do_frame("b2b0", 8'h00, 1'b1);
    do_frame("b2b1", 8'hFF, 1'b1);
    chk("b2b1_spacing", dv_cyc - prev_dv_cyc, 80);
    do_frame("b2b2", 8'h5A, 1'b1);
    chk("b2b2_spacing", dv_cyc - prev_dv_cyc, 80);
    idle(5);

    // Two-clock low glitch.
    dv0 = dv_cnt; fe0 = fe_cnt;
    active_seen = 0;
    bus.i_Rx_Serial = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(30);
    chk("glitch_dv", dv_cnt - dv0, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);
    chk("glitch_active", active_seen, 0);
    do_frame("after_glitch", 8'h3C, 1'b1);
    idle(5);

    // A bad stop bit after a good byte.
    do_frame("good11", 8'h11, 1'b1);
    do_frame("bad3c", 8'h3C, 1'b0);
    chk("bad3c_held", bus.o_Rx_Byte, 8'h11);

    // Line held low for 20 bit times.
    dv0 = dv_cnt; fe0 = fe_cnt; brk0 = brk_cnt;
    bus.i_Rx_Serial = 1'b0;
    repeat (20 * CPB) @(posedge clk);
    #1;
    chk("brk_fe", fe_cnt - fe0, 1);
    chk("brk_brk", brk_cnt - brk0, 1);
    chk("brk_dv", dv_cnt - dv0, 0);
    idle(2 * CPB);
    chk("brk_fe_after", fe_cnt - fe0, 1);
    do_frame("after_brk", 8'h81, 1'b1);
    idle(5);

    // Reset during data bit 4 of 0xC3.
    dv0 = dv_cnt;
    set_bit(1'b0);
    for (int i = 0; i < 4; i++) set_bit(((8'hC3 >> i) & 8'h01) != 0);
    bus.i_Rx_Serial = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_byte = 8'h00;
    chk("midrst_byte", bus.o_Rx_Byte, 8'h00);
    chk("midrst_active", bus.o_Rx_Active, 0);
    chk("midrst_dv", bus.o_Rx_DV, 0);
    chk("midrst_fe", bus.o_Frame_Err, 0);
    rst = 1'b0;
    idle(3 * CPB);
    chk("midrst_no_dv", dv_cnt - dv0, 0);
    do_frame("after_rst", 8'h7E, 1'b1);
    idle(5);

    // Random frames: mostly good stop bits, with random idle gaps.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] rb;
      logic       rs;
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      do_frame("rand", rb, rs);
      idle($urandom_range(0, 3));
    end

    chk("no_dv_fe_overlap", overlap_cnt, 0);
    chk("no_brk_without_fe", brk_alone_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
